stopwatch_lap_ctrl: RTL and testbench

Sequencing controller for the stopwatch datapath. Turns debounced button pulses into run/stop/clear commands, captures lap (split) times from the datapath's live time fields into a small lap buffer, and lets the user step through stored laps while stopped. It sits between the button debouncers and the stopwatch datapath and display mux, and replaces the simple run/stop/clear control unit when lap support is enabled.

---
 rtl/stopwatch_lap_ctrl_pkg.sv | 23 ++
 rtl/stopwatch_lap_ctrl_lap_buffer.sv | 93 +++++++++
 rtl/stopwatch_lap_ctrl.sv | 177 +++++++++++++++++
 tb/tb_stopwatch_lap_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_lap_ctrl_pkg.sv
// Shared types for the stopwatch lap controller.
// Contents: FSM state encoding, default time-field width, lap record layout.
// The record is the packed {hour, min, sec, msec} view of one stored lap.
package stopwatch_lap_ctrl_pkg;

    localparam int TW_DEF = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_CLR  = 2'd3
    } state_e;

    // Lap record at the default field width, for datapath/display consumers.
    typedef struct packed {
        logic [TW_DEF-1:0] hour;
        logic [TW_DEF-1:0] min;
        logic [TW_DEF-1:0] sec;
        logic [TW_DEF-1:0] msec;
    } lap_rec_t;

endpackage

// File: rtl/stopwatch_lap_ctrl_lap_buffer.sv
// Lap buffer: DEPTH-entry register file filled in order, with a registered read port.
// Ports: wr_en_i/wr_dat_i append at entry[count]; clr_i empties; view_i/view_idx_i pick the entry,
// otherwise the newest one is shown. count_o/full_o/rd_dat_o/rd_idx_o are all registered.
module stopwatch_lap_ctrl_lap_buffer #(
    parameter int DEPTH = 4,
    parameter int W     = 28
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [W-1:0]             wr_dat_i,
    input  logic                     clr_i,
    input  logic                     view_i,
    input  logic [$clog2(DEPTH)-1:0] view_idx_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic [W-1:0]             rd_dat_o,
    output logic [$clog2(DEPTH)-1:0] rd_idx_o
);

    localparam int          IW       = $clog2(DEPTH);
    localparam logic [IW:0] FULL_CNT = (IW+1)'(DEPTH);
    localparam logic [IW:0] CNT_ONE  = (IW+1)'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [IW:0]   count_q;
    logic [IW:0]   count_d;
    logic [IW:0]   count_m1;
    logic          full_q;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] sel_idx;
    logic [IW-1:0] rd_idx_q;
    logic [IW-1:0] rd_idx_d;
    logic [W-1:0]  rd_dat_q;
    logic [W-1:0]  rd_dat_d;

    // The controller only writes while count < DEPTH, so the low bits are a valid slot.
    assign wr_idx = count_q[IW-1:0];

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (wr_en_i) begin
            count_d = count_q + CNT_ONE;
        end
    end

    assign count_m1 = count_d - CNT_ONE;

    // Read side works from next-state values so the outputs settle on the same edge
    // as the write or index change; a same-edge write is forwarded past the array.
    always_comb begin
        sel_idx  = view_i ? view_idx_i : count_m1[IW-1:0];
        rd_idx_d = '0;
        rd_dat_d = '0;
        if (count_d != '0) begin
            rd_idx_d = sel_idx;
            if (wr_en_i && (sel_idx == wr_idx)) begin
                rd_dat_d = wr_dat_i;
            end else begin
                rd_dat_d = mem_q[sel_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            full_q   <= 1'b0;
            rd_dat_q <= '0;
            rd_idx_q <= '0;
        end else begin
            count_q  <= count_d;
            full_q   <= (count_d == FULL_CNT);
            rd_dat_q <= rd_dat_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    // Entry contents need no reset: nothing is read until it has been written.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx] <= wr_dat_i;
        end
    end

    assign count_o  = count_q;
    assign full_o   = full_q;
    assign rd_dat_o = rd_dat_q;
    assign rd_idx_o = rd_idx_q;

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch sequencing controller with lap capture: buttons -> run/clear, lap buffer, lap viewing.
// Ports: debounced button pulses and live time in; o_run/o_clear/o_view_lap plus selected lap entry,
// its index, lap count/full and a sticky overflow out. All outputs registered (one cycle after input).
module stopwatch_lap_ctrl
    import stopwatch_lap_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TW    = TW_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_btn_runstop,
    input  logic                     i_btn_clear,
    input  logic                     i_btn_lap,
    input  logic [TW-1:0]            i_msec,
    input  logic [TW-1:0]            i_sec,
    input  logic [TW-1:0]            i_min,
    input  logic [TW-1:0]            i_hour,
    output logic                     o_run,
    output logic                     o_clear,
    output logic                     o_view_lap,
    output logic [TW-1:0]            o_lap_msec,
    output logic [TW-1:0]            o_lap_sec,
    output logic [TW-1:0]            o_lap_min,
    output logic [TW-1:0]            o_lap_hour,
    output logic [$clog2(DEPTH)-1:0] o_lap_idx,
    output logic [$clog2(DEPTH):0]   o_lap_count,
    output logic                     o_lap_full,
    output logic                     o_lap_ovf
);

    localparam int            IW      = $clog2(DEPTH);
    localparam logic [IW:0]   CNT_ONE = (IW+1)'(1);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);

    typedef struct packed {
        logic [TW-1:0] hour;
        logic [TW-1:0] min;
        logic [TW-1:0] sec;
        logic [TW-1:0] msec;
    } lap_t;

    state_e        state_q;
    state_e        state_d;
    logic          run_q;
    logic          clear_q;
    logic          view_q;
    logic          view_d;
    logic [IW-1:0] vidx_q;
    logic [IW-1:0] vidx_d;
    logic          ovf_q;
    logic          ovf_d;

    logic          btn_rs;
    logic          btn_clr;
    logic          btn_lap;
    logic          lap_wr;
    logic          lap_clr;
    logic [IW:0]   lap_count;
    logic [IW:0]   count_m1;
    logic          lap_full;
    lap_t          wr_rec;
    lap_t          rd_rec;

    // One winning button per cycle; losers are dropped even if the winner is ignored.
    assign btn_rs  = i_btn_runstop;
    assign btn_clr = i_btn_clear & ~i_btn_runstop;
    assign btn_lap = i_btn_lap & ~i_btn_clear & ~i_btn_runstop;

    assign wr_rec   = '{hour: i_hour, min: i_min, sec: i_sec, msec: i_msec};
    assign count_m1 = lap_count - CNT_ONE;

    always_comb begin
        state_d = state_q;
        view_d  = view_q;
        vidx_d  = vidx_q;
        ovf_d   = ovf_q;
        lap_wr  = 1'b0;
        lap_clr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (btn_rs) begin
                    state_d = ST_RUN;
                end else if (btn_clr) begin
                    state_d = ST_CLR;
                end
            end
            ST_RUN: begin
                if (btn_rs) begin
                    state_d = ST_STOP;
                end else if (btn_lap) begin
                    if (lap_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        lap_wr = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (btn_rs) begin
                    state_d = ST_RUN;
                end else if (btn_clr) begin
                    state_d = ST_CLR;
                end else if (btn_lap && (lap_count != '0)) begin
                    if (!view_q) begin
                        view_d = 1'b1;
                        vidx_d = '0;
                    end else if (vidx_q == count_m1[IW-1:0]) begin
                        vidx_d = '0;
                    end else begin
                        vidx_d = vidx_q + IDX_ONE;
                    end
                end
            end
            ST_CLR: begin
                state_d = ST_IDLE;
                lap_clr = 1'b1;
                ovf_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Viewing only exists while stopped; any other next state drops it.
        if (state_d != ST_STOP) begin
            view_d = 1'b0;
            vidx_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
            clear_q <= 1'b0;
            view_q  <= 1'b0;
            vidx_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= (state_d == ST_RUN);
            clear_q <= (state_d == ST_CLR);
            view_q  <= view_d;
            vidx_q  <= vidx_d;
            ovf_q   <= ovf_d;
        end
    end

    stopwatch_lap_ctrl_lap_buffer #(
        .DEPTH (DEPTH),
        .W     (4*TW)
    ) u_lap_buffer (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (lap_wr),
        .wr_dat_i   (wr_rec),
        .clr_i      (lap_clr),
        .view_i     (view_d),
        .view_idx_i (vidx_d),
        .count_o    (lap_count),
        .full_o     (lap_full),
        .rd_dat_o   (rd_rec),
        .rd_idx_o   (o_lap_idx)
    );

    assign o_run       = run_q;
    assign o_clear     = clear_q;
    assign o_view_lap  = view_q;
    assign o_lap_ovf   = ovf_q;
    assign o_lap_count = lap_count;
    assign o_lap_full  = lap_full;
    assign o_lap_hour  = rd_rec.hour;
    assign o_lap_min   = rd_rec.min;
    assign o_lap_sec   = rd_rec.sec;
    assign o_lap_msec  = rd_rec.msec;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
module tb_stopwatch_lap_ctrl;

    localparam int DEPTH = 4;
    localparam int TW    = 7;
    localparam int IW    = 2;

    localparam int S_RUN  = 0;
    localparam int S_CLR  = 1;
    localparam int S_VIEW = 2;
    localparam int S_MSEC = 3;
    localparam int S_SEC  = 4;
    localparam int S_MIN  = 5;
    localparam int S_HOUR = 6;
    localparam int S_IDX  = 7;
    localparam int S_CNT  = 8;
    localparam int S_FULL = 9;
    localparam int S_OVF  = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rs  = 1'b0;
    logic cl  = 1'b0;
    logic lp  = 1'b0;
    logic [TW-1:0] t_msec = '0;
    logic [TW-1:0] t_sec  = '0;
    logic [TW-1:0] t_min  = '0;
    logic [TW-1:0] t_hour = '0;

    logic          o_run, o_clear, o_view_lap, o_lap_full, o_lap_ovf;
    logic [TW-1:0] o_lap_msec, o_lap_sec, o_lap_min, o_lap_hour;
    logic [IW-1:0] o_lap_idx;
    logic [IW:0]   o_lap_count;

    int errors = 0;
    int checks = 0;

    // Scoreboard: one entry per expected observation, drained after the DUT edge.
    string tag_q[$];
    int    sig_q[$];
    int    val_q[$];

    // Reference lap store: {hour, min, sec, msec} packed as 4 bytes.
    int laps[$];
    int ovf_m = 0;

    always #5 clk = ~clk;

    stopwatch_lap_ctrl #(.DEPTH(DEPTH), .TW(TW)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_btn_runstop (rs),
        .i_btn_clear   (cl),
        .i_btn_lap     (lp),
        .i_msec        (t_msec),
        .i_sec         (t_sec),
        .i_min         (t_min),
        .i_hour        (t_hour),
        .o_run         (o_run),
        .o_clear       (o_clear),
        .o_view_lap    (o_view_lap),
        .o_lap_msec    (o_lap_msec),
        .o_lap_sec     (o_lap_sec),
        .o_lap_min     (o_lap_min),
        .o_lap_hour    (o_lap_hour),
        .o_lap_idx     (o_lap_idx),
        .o_lap_count   (o_lap_count),
        .o_lap_full    (o_lap_full),
        .o_lap_ovf     (o_lap_ovf)
    );

    function automatic logic [31:0] obs(input int sig);
        logic [31:0] v;
        case (sig)
            S_RUN:   v = 32'(o_run);
            S_CLR:   v = 32'(o_clear);
            S_VIEW:  v = 32'(o_view_lap);
            S_MSEC:  v = 32'(o_lap_msec);
            S_SEC:   v = 32'(o_lap_sec);
            S_MIN:   v = 32'(o_lap_min);
            S_HOUR:  v = 32'(o_lap_hour);
            S_IDX:   v = 32'(o_lap_idx);
            S_CNT:   v = 32'(o_lap_count);
            S_FULL:  v = 32'(o_lap_full);
            default: v = 32'(o_lap_ovf);
        endcase
        return v;
    endfunction

    task automatic push_exp(input string tag, input int sig, input int val);
        tag_q.push_back(tag);
        sig_q.push_back(sig);
        val_q.push_back(val);
    endtask

    task automatic drain();
        string       t;
        int          s;
        logic [31:0] e;
        logic [31:0] o;
        while (tag_q.size() > 0) begin
            t = tag_q.pop_front();
            s = sig_q.pop_front();
            e = 32'(val_q.pop_front());
            o = obs(s);
            checks++;
            assert (o === e) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", t, o, e);
            end
        end
    endtask

    task automatic exp_lap(input string tag, input int rec);
        push_exp({tag, ".hour"}, S_HOUR, (rec >> 24) & 8'hff);
        push_exp({tag, ".min"},  S_MIN,  (rec >> 16) & 8'hff);
        push_exp({tag, ".sec"},  S_SEC,  (rec >> 8)  & 8'hff);
        push_exp({tag, ".msec"}, S_MSEC, rec & 8'hff);
    endtask

    task automatic exp_all_zero(input string tag);
        for (int s = S_RUN; s <= S_OVF; s++) push_exp(tag, s, 0);
    endtask

    task automatic set_time(input int h, input int m, input int s, input int ms);
        t_hour = TW'(h);
        t_min  = TW'(m);
        t_sec  = TW'(s);
        t_msec = TW'(ms);
    endtask

    // Drive one cycle of button pulses from a negedge; return at the following negedge.
    task automatic cyc(input logic r, input logic c, input logic l);
        rs = r;
        cl = c;
        lp = l;
        @(posedge clk);
        @(negedge clk);
        rs = 1'b0;
        cl = 1'b0;
        lp = 1'b0;
    endtask

    // Lap press while running; expectations come from the reference store.
    task automatic lap_run(input int h, input int m, input int s, input int ms);
        set_time(h, m, s, ms);
        if (laps.size() < DEPTH) laps.push_back((h << 24) | (m << 16) | (s << 8) | ms);
        else ovf_m = 1;
        push_exp("lap_cnt",  S_CNT,  laps.size());
        push_exp("lap_full", S_FULL, (laps.size() == DEPTH) ? 1 : 0);
        push_exp("lap_ovf",  S_OVF,  ovf_m);
        push_exp("lap_idx",  S_IDX,  laps.size() - 1);
        push_exp("lap_view", S_VIEW, 0);
        push_exp("lap_run",  S_RUN,  1);
        exp_lap("lap_newest", laps[laps.size()-1]);
        cyc(1'b0, 1'b0, 1'b1);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        exp_all_zero("reset");
        drain();
        rst = 1'b1;
        @(negedge clk);

        // Run / stop toggling, no clear pulse
        push_exp("rs1_run", S_RUN, 1); push_exp("rs1_clr", S_CLR, 0);
        cyc(1'b1, 1'b0, 1'b0); drain();
        push_exp("rs2_run", S_RUN, 0); push_exp("rs2_clr", S_CLR, 0);
        cyc(1'b1, 1'b0, 1'b0); drain();
        push_exp("rs3_run", S_RUN, 1); push_exp("rs3_clr", S_CLR, 0);
        cyc(1'b1, 1'b0, 1'b0); drain();

        // Lap capture up to full, then overflow
        lap_run(0, 0, 12, 34);
        lap_run(0, 1, 15, 0);
        lap_run(2, 3, 20, 50);
        lap_run(1, 59, 25, 99);
        lap_run(0, 2, 30, 11);
        set_time(5, 6, 7, 8);

        // Clear while running is ignored
        push_exp("clr_run_run", S_RUN, 1); push_exp("clr_run_clr", S_CLR, 0);
        push_exp("clr_run_cnt", S_CNT, 4);
        cyc(1'b0, 1'b1, 1'b0); drain();

        // Stop, then step through stored laps with wrap
        push_exp("stop_run", S_RUN, 0); push_exp("stop_view", S_VIEW, 0);
        cyc(1'b1, 1'b0, 1'b0); drain();
        for (int k = 0; k < 5; k++) begin
            push_exp("view_on",  S_VIEW, 1);
            push_exp("view_idx", S_IDX,  k % DEPTH);
            push_exp("view_ovf", S_OVF,  1);
            exp_lap("view_dat", laps[k % DEPTH]);
            cyc(1'b0, 1'b0, 1'b1); drain();
        end
        push_exp("resume_view", S_VIEW, 0); push_exp("resume_run", S_RUN, 1);
        push_exp("resume_idx", S_IDX, 3);
        exp_lap("resume_dat", laps[3]);
        cyc(1'b1, 1'b0, 1'b0); drain();

        // Stop, clear: one-cycle pulse then everything zeroed
        push_exp("stop2_run", S_RUN, 0);
        cyc(1'b1, 1'b0, 1'b0); drain();
        push_exp("clr_pulse", S_CLR, 1); push_exp("clr_run", S_RUN, 0);
        push_exp("clr_view", S_VIEW, 0);
        cyc(1'b0, 1'b1, 1'b0); drain();
        laps.delete();
        ovf_m = 0;
        push_exp("clr_done", S_CLR, 0); push_exp("clr_cnt", S_CNT, 0);
        push_exp("clr_full", S_FULL, 0); push_exp("clr_ovf", S_OVF, 0);
        push_exp("clr_idx", S_IDX, 0);
        exp_lap("clr_dat", 0);
        cyc(1'b0, 1'b0, 1'b0); drain();

        // Lap in IDLE ignored
        push_exp("idle_lap_cnt", S_CNT, 0); push_exp("idle_lap_run", S_RUN, 0);
        push_exp("idle_lap_view", S_VIEW, 0); push_exp("idle_lap_clr", S_CLR, 0);
        cyc(1'b0, 1'b0, 1'b1); drain();

        // Lap in STOP with no laps ignored
        push_exp("run_b", S_RUN, 1);
        cyc(1'b1, 1'b0, 1'b0); drain();
        push_exp("stop_b", S_RUN, 0);
        cyc(1'b1, 1'b0, 1'b0); drain();
        push_exp("stop0_view", S_VIEW, 0); push_exp("stop0_cnt", S_CNT, 0);
        cyc(1'b0, 1'b0, 1'b1); drain();

        // runstop beats clear in STOP
        push_exp("run_c", S_RUN, 1);
        cyc(1'b1, 1'b0, 1'b0); drain();
        lap_run(1, 2, 3, 4);
        push_exp("stop_c", S_RUN, 0);
        cyc(1'b1, 1'b0, 1'b0); drain();
        push_exp("rsclr_run", S_RUN, 1); push_exp("rsclr_clr", S_CLR, 0);
        push_exp("rsclr_cnt", S_CNT, 1);
        cyc(1'b1, 1'b1, 1'b0); drain();
        push_exp("rsclr_clr2", S_CLR, 0); push_exp("rsclr_cnt2", S_CNT, 1);
        cyc(1'b0, 1'b0, 1'b0); drain();

        // clear beats lap in STOP
        push_exp("stop_d", S_RUN, 0);
        cyc(1'b1, 1'b0, 1'b0); drain();
        push_exp("clrlap_clr", S_CLR, 1); push_exp("clrlap_view", S_VIEW, 0);
        cyc(1'b0, 1'b1, 1'b1); drain();
        laps.delete();
        push_exp("clrlap_clr2", S_CLR, 0); push_exp("clrlap_cnt", S_CNT, 0);
        push_exp("clrlap_view2", S_VIEW, 0);
        cyc(1'b0, 1'b0, 1'b0); drain();

        // Async reset mid-RUN with two laps stored
        push_exp("run_e", S_RUN, 1);
        cyc(1'b1, 1'b0, 1'b0); drain();
        lap_run(3, 4, 5, 6);
        lap_run(7, 8, 9, 10);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        exp_all_zero("async_rst");
        drain();
        laps.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_exp("post_rst_cnt", S_CNT, 0); push_exp("post_rst_run", S_RUN, 0);
        exp_lap("post_rst_dat", 0);
        cyc(1'b0, 1'b0, 1'b1); drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
